// File: rtl/counter_checker_pkg.sv
// Shared state encoding and default parameter values for the counter sequence checker.
package counter_checker_pkg;

  localparam int DEF_WIDTH          = 3;
  localparam int DEF_LOCK_THRESHOLD = 8;
  localparam int DEF_ERR_W          = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2,
    ST_UNUSED = 2'd3
  } chk_state_t;

endpackage

// File: rtl/counter_sequence_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; clr together with inc restarts the count at one.
module sat_counter #(
  parameter int             W   = 8,
  parameter logic [W-1:0]   MAX = {W{1'b1}}
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_p1;

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (v >= MAX) ? v : v + W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      count_p1 <= '0;
    end else if (clr) begin
      count_p1 <= inc ? W'(1) : '0;
    end else if (inc) begin
      count_p1 <= sat_inc(count_p1);
    end
  end

  assign count = count_p1;

endmodule

// File: rtl/counter_sequence_checker.sv
// Watches a free-running counter/LED bus, predicts each next step, and reports lock, errors and wraps.
module counter_sequence_checker
  import counter_checker_pkg::*;
#(
  parameter int WIDTH          = DEF_WIDTH,
  parameter int LOCK_THRESHOLD = DEF_LOCK_THRESHOLD,
  parameter int ERR_W          = DEF_ERR_W
) (
  input  logic             input_clock1_1,
  input  logic             input_reset1_1,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             sample_valid,
  output logic [WIDTH-1:0] expected,
  output logic             locked,
  output logic             error_pulse,
  output logic [ERR_W-1:0] error_count,
  output logic [ERR_W-1:0] wrap_count,
  output logic [1:0]       state
);

  localparam int               RUN_W       = $clog2(LOCK_THRESHOLD + 1);
  localparam logic [RUN_W-1:0] RUN_MAX     = RUN_W'(LOCK_THRESHOLD);
  localparam logic [RUN_W-1:0] RUN_PRELOCK = RUN_W'(LOCK_THRESHOLD - 1);

  chk_state_t       state_p1;
  chk_state_t       state_nxt;
  logic [WIDTH-1:0] expected_p1;
  logic             error_pulse_p1;
  logic [RUN_W-1:0] run_p1;

  logic is_match;
  logic seeding;
  logic tracking;
  logic mismatch;
  logic wrap_hit;
  logic run_clr;
  logic run_inc;

  function automatic logic [WIDTH-1:0] succ(input logic [WIDTH-1:0] v);
    return v + WIDTH'(1);
  endfunction

  // An unknown sample compares false here and therefore lands on the mismatch path.
  always_comb begin
    is_match = 1'b0;
    if (sample_in == expected_p1) is_match = 1'b1;
  end

  assign seeding  = sample_valid && (state_p1 == ST_IDLE);
  assign tracking = sample_valid && ((state_p1 == ST_TRACK) || (state_p1 == ST_LOCKED));
  assign mismatch = tracking && !is_match;
  // A matched zero can only follow an all-ones step, so it marks one counter wrap.
  assign wrap_hit = tracking && is_match && (sample_in == '0);
  assign run_clr  = seeding || mismatch;
  assign run_inc  = seeding || tracking;

  always_ff @(posedge input_clock1_1) begin
    if (input_reset1_1) state_p1 <= ST_IDLE;
    else                state_p1 <= state_nxt;
  end

  always_comb begin
    state_nxt = state_p1;
    case (state_p1)
      ST_IDLE: begin
        if (sample_valid) state_nxt = ST_TRACK;
      end
      ST_TRACK: begin
        if (sample_valid) begin
          if (is_match && (run_p1 >= RUN_PRELOCK)) state_nxt = ST_LOCKED;
          else                                      state_nxt = ST_TRACK;
        end
      end
      ST_LOCKED: begin
        if (sample_valid && !is_match) state_nxt = ST_TRACK;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    state       = state_p1;
    locked      = (state_p1 == ST_LOCKED);
    expected    = expected_p1;
    error_pulse = error_pulse_p1;
  end

  // Prediction and error strobe, registered on the sample_valid cycle.
  always_ff @(posedge input_clock1_1) begin
    if (input_reset1_1) begin
      expected_p1    <= '0;
      error_pulse_p1 <= 1'b0;
    end else begin
      error_pulse_p1 <= mismatch;
      if (run_clr)       expected_p1 <= succ(sample_in);
      else if (tracking) expected_p1 <= succ(expected_p1);
    end
  end

  sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk   (input_clock1_1),
    .rst   (input_reset1_1),
    .clr   (1'b0),
    .inc   (mismatch),
    .count (error_count)
  );

  sat_counter #(.W(ERR_W)) u_wrap_cnt (
    .clk   (input_clock1_1),
    .rst   (input_reset1_1),
    .clr   (1'b0),
    .inc   (wrap_hit),
    .count (wrap_count)
  );

  sat_counter #(.W(RUN_W), .MAX(RUN_MAX)) u_run_cnt (
    .clk   (input_clock1_1),
    .rst   (input_reset1_1),
    .clr   (run_clr),
    .inc   (run_inc),
    .count (run_p1)
  );

endmodule

// File: tb/tb_counter_sequence_checker.sv
// Bench for counter_sequence_checker: directed vector table, corner sequences, and random traffic vs. a reference model.
module tb_counter_sequence_checker;

  localparam int WIDTH = 3;
  localparam int THR   = 8;
  localparam int ERR_W = 8;
  localparam int M     = 1 << WIDTH;
  localparam int EMAX  = (1 << ERR_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [WIDTH-1:0] sample_in = '0;
  logic             sample_valid = 1'b0;
  logic [WIDTH-1:0] expected;
  logic             locked;
  logic             error_pulse;
  logic [ERR_W-1:0] error_count;
  logic [ERR_W-1:0] wrap_count;
  logic [1:0]       state;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: sequence-level view of the checker.
  bit m_seeded;
  int m_exp;
  int m_run;
  int m_err;
  int m_wrap;
  bit m_pulse;

  counter_sequence_checker #(
    .WIDTH(WIDTH), .LOCK_THRESHOLD(THR), .ERR_W(ERR_W)
  ) dut (
    .input_clock1_1 (clk),
    .input_reset1_1 (rst),
    .sample_in      (sample_in),
    .sample_valid   (sample_valid),
    .expected       (expected),
    .locked         (locked),
    .error_pulse    (error_pulse),
    .error_count    (error_count),
    .wrap_count     (wrap_count),
    .state          (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit r;
    bit v;
    int s;
    int e_exp;
    bit e_lock;
    bit e_pulse;
    int e_err;
    int e_wrap;
    int e_state;
  } vec_t;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
  endtask

  task automatic model_update(input bit r, input bit v, input int s);
    if (r) begin
      m_seeded = 0; m_exp = 0; m_run = 0; m_err = 0; m_wrap = 0; m_pulse = 0;
    end else if (!v) begin
      m_pulse = 0;
    end else if (!m_seeded) begin
      m_seeded = 1; m_exp = (s + 1) % M; m_run = 1; m_pulse = 0;
    end else if (s == m_exp) begin
      if (s == 0) m_wrap = (m_wrap < EMAX) ? m_wrap + 1 : EMAX;
      m_exp   = (m_exp + 1) % M;
      m_run   = (m_run < THR) ? m_run + 1 : THR;
      m_pulse = 0;
    end else begin
      m_pulse = 1;
      m_err   = (m_err < EMAX) ? m_err + 1 : EMAX;
      m_run   = 1;
      m_exp   = (s + 1) % M;
    end
  endtask

  function automatic int model_state();
    if (!m_seeded) return 0;
    return (m_run >= THR) ? 2 : 1;
  endfunction

  task automatic step(input bit r, input bit v, input int s);
    rst = r; sample_valid = v; sample_in = WIDTH'(s);
    @(posedge clk);
    model_update(r, v, s);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".expected"},    int'(expected),    m_exp);
    chk({tag, ".locked"},      int'(locked),      int'(model_state() == 2));
    chk({tag, ".error_pulse"}, int'(error_pulse), int'(m_pulse));
    chk({tag, ".error_count"}, int'(error_count), m_err);
    chk({tag, ".wrap_count"},  int'(wrap_count),  m_wrap);
    chk({tag, ".state"},       int'(state),       model_state());
  endtask

  vec_t vecs[$];

  function automatic vec_t mk(bit r, bit v, int s, int ex, bit lk, bit pu, int er, int wr, int st);
    vec_t t;
    t.r = r; t.v = v; t.s = s; t.e_exp = ex; t.e_lock = lk; t.e_pulse = pu;
    t.e_err = er; t.e_wrap = wr; t.e_state = st;
    return t;
  endfunction

  initial begin
    //            r  v  s  exp lk pu err wrap st
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 2, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 2, 3, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 3, 4, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 4, 5, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 5, 6, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 6, 7, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 7, 0, 1, 0, 0, 0, 2));
    vecs.push_back(mk(0, 1, 0, 1, 1, 0, 0, 1, 2));
    vecs.push_back(mk(0, 1, 1, 2, 1, 0, 0, 1, 2));
    vecs.push_back(mk(0, 1, 2, 3, 1, 0, 0, 1, 2));
    vecs.push_back(mk(0, 1, 5, 6, 0, 1, 1, 1, 1));
    vecs.push_back(mk(0, 0, 0, 6, 0, 0, 1, 1, 1));
    vecs.push_back(mk(1, 1, 3, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 6, 7, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 7, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 1, 0, 0, 0, 1, 1));

    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      step(vecs[i].r, vecs[i].v, vecs[i].s);
      chk({tag, ".expected"},    int'(expected),    vecs[i].e_exp);
      chk({tag, ".locked"},      int'(locked),      int'(vecs[i].e_lock));
      chk({tag, ".error_pulse"}, int'(error_pulse), int'(vecs[i].e_pulse));
      chk({tag, ".error_count"}, int'(error_count), vecs[i].e_err);
      chk({tag, ".wrap_count"},  int'(wrap_count),  vecs[i].e_wrap);
      chk({tag, ".state"},       int'(state),       vecs[i].e_state);
    end

    // Mismatch one step short of lock: no lock, error counted.
    step(1, 0, 0);
    for (int k = 0; k < THR - 1; k++) begin
      step(0, 1, k);
      check_model("prelock");
    end
    step(0, 1, 3);
    check_model("prelock_mis");
    chk("prelock_mis.locked_const", int'(locked), 0);
    chk("prelock_mis.state_const",  int'(state),  1);
    chk("prelock_mis.err_const",    int'(error_count), 1);

    // Lock, then hold valid low for 20 cycles.
    for (int k = 0; k < THR; k++) step(0, 1, (4 + k) % M);
    check_model("lock2");
    chk("lock2.locked_const", int'(locked), 1);
    for (int k = 0; k < 20; k++) begin
      step(0, 0, $urandom_range(0, M - 1));
      check_model("idle_hold");
    end
    chk("idle_hold.expected_const", int'(expected), (4 + THR) % M);

    // Reset coincident with a valid sample while locked.
    step(0, 1, m_exp);
    chk("pre_rst.locked", int'(locked), 1);
    step(1, 1, m_exp);
    chk("rst_valid.state",    int'(state),       0);
    chk("rst_valid.expected", int'(expected),    0);
    chk("rst_valid.locked",   int'(locked),      0);
    chk("rst_valid.err",      int'(error_count), 0);
    chk("rst_valid.wrap",     int'(wrap_count),  0);
    chk("rst_valid.pulse",    int'(error_pulse), 0);

    // 300 alternating mismatches drive error_count into saturation.
    step(0, 1, 0);
    for (int k = 0; k < 300; k++) begin
      step(0, 1, (k % 2 == 0) ? 4 : 0);
      check_model("sat");
    end
    chk("sat.err_const", int'(error_count), EMAX);
    step(0, 1, 2);
    chk("sat_hold.err_const", int'(error_count), EMAX);
    chk("sat_hold.pulse",     int'(error_pulse), 1);

    // Randomized traffic against the model.
    step(1, 0, 0);
    for (int k = 0; k < 3000; k++) begin
      bit r;
      bit v;
      int s;
      r = ($urandom_range(0, 199) == 0);
      v = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 9) < 8) ? m_exp : int'($urandom_range(0, M - 1));
      step(r, v, s);
      check_model("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
